// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and divide special cases handled up front.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;      // raw op_b until PREP, then multiplicand / divisor magnitude
    logic [2*XLEN-1:0] acc;      // {hi, lo}: product, or {remainder, dividend/quotient}
    logic              neg;
    logic              spec;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, special, res_neg;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quot, remd, fix_res;

    assign is_div      = f3[2];
    assign a_signed    = is_div ? ~f3[0] : (f3[1] ^ f3[0]);
    assign b_signed    = is_div ? ~f3[0] : (f3[1:0] == 2'b01);
    assign a_neg       = a_signed & opa[XLEN-1];
    assign b_neg       = b_signed & opb[XLEN-1];
    assign abs_a       = a_neg ? -opa : opa;
    assign abs_b       = b_neg ? -opb : opb;
    assign div_zero    = is_div && (opb == '0);
    assign div_ovf     = is_div && !f3[0] && (opa == INT_MIN) && (opb == '1);
    assign special     = div_zero | div_ovf;
    assign special_res = div_zero ? (f3[1] ? opa : '1) : (f3[1] ? '0 : INT_MIN);
    // Remainder takes the dividend's sign; everything else is negative iff signs differ.
    assign res_neg     = (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, acc[XLEN-1:1]};
    assign div_sh   = acc[2*XLEN-1:XLEN-1];
    assign div_diff = div_sh - {1'b0, opb};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod    = neg ? -acc : acc;
    assign quot    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign remd    = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = is_div ? (f3[1] ? remd : quot)
                   : ((f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    assign ready_o = (state == IDLE) || (state == DONE);
    assign busy_o  = (state == PREP) || (state == CALC) || (state == FIX);
    assign stall_o = ((state == IDLE) && valid_i && !flush_i) || busy_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            f3       <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            spec     <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (valid_i) begin
                            f3    <= funct3_i;
                            opa   <= op_a_i;
                            opb   <= op_b_i;
                            state <= PREP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PREP: begin
                        neg  <= res_neg;
                        spec <= special;
                        cnt  <= CW'(XLEN - 1);
                        // Special cases skip CALC and resolve in FIX (2-cycle latency).
                        if (special) begin
                            acc   <= {{XLEN{1'b0}}, special_res};
                            state <= FIX;
                        end else begin
                            opb   <= is_div ? abs_b : abs_a;
                            acc   <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= FIX;
                    end
                    FIX: begin
                        result_o <= spec ? acc[XLEN-1:0] : fix_res;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed and random ops against a cycle-level
// behavioural model built on native 64-bit arithmetic.
module tb_muldiv_sequencer;

    logic        clk = 0, rst_ni = 1, valid_i = 0, flush_i = 0;
    logic [2:0]  funct3_i = 0;
    logic [31:0] op_a_i = 0, op_b_i = 0;
    logic        ready_o, busy_o, stall_o, valid_o;
    logic [31:0] result_o;

    int pass_cnt = 0, total_cnt = 0;

    // model: cycles left until the result appears, DONE flag, visible and pending result
    int          m_cnt = 0;
    bit          m_done = 0;
    logic [31:0] m_res = 0, m_pend = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i), .ready_o(ready_o),
        .busy_o(busy_o), .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        int ia = a;
        int ib = b;
        logic [63:0] p;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit spec_case(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Compare DUT against the model every cycle, then advance the model using
    // the inputs that the next rising edge will sample.
    initial forever begin
        @(negedge clk);
        if (!rst_ni) begin
            m_cnt = 0; m_done = 0; m_res = 0;
        end
        chk("valid_o", valid_o, m_done);
        chk("ready_o", ready_o, m_cnt == 0);
        chk("busy_o",  busy_o,  m_cnt != 0);
        chk("stall_o", stall_o, (m_cnt != 0) || (!m_done && valid_i && !flush_i));
        chk("result_o", result_o, m_res);
        if (rst_ni) begin
            if (flush_i) begin
                m_cnt = 0; m_done = 0;
            end else if (m_cnt == 0 && valid_i) begin
                m_cnt  = spec_case(funct3_i, op_a_i, op_b_i) ? 2 : 34;
                m_pend = ref_op(funct3_i, op_a_i, op_b_i);
                m_done = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin m_done = 1; m_res = m_pend; end
            end else begin
                m_done = 0;
            end
        end
    end

    // Issue one op (caller is at posedge+1 in IDLE or DONE); optionally wiggle inputs while busy.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit junk, output logic [31:0] res, output int lat);
        int n = 0;
        valid_i = 1; funct3_i = f; op_a_i = a; op_b_i = b; flush_i = 0;
        @(posedge clk); #1;
        valid_i = 0;
        while (n < 100) begin
            if (junk) begin
                valid_i = 1'($urandom_range(0, 1));
                funct3_i = 3'($urandom); op_a_i = $urandom; op_b_i = $urandom;
            end
            @(posedge clk); #1;
            n++;
            if (valid_o) break;
        end
        valid_i = 0;
        chk("op completes", valid_o, 1);
        res = result_o;
        lat = n;
    endtask

    task automatic dir(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] r;
        int l;
        run_op(f, a, b, 0, r, l);
        chk({name, " result"}, r, exp);
        chk({name, " latency"}, l, exp_lat);
    endtask

    initial begin
        logic [31:0] r, ra, rb;
        logic [2:0]  rf;
        int          l;
        bit          seen;

        #2 rst_ni = 0;
        #1;
        chk("reset valid_o", valid_o, 0);
        chk("reset busy_o", busy_o, 0);
        chk("reset ready_o", ready_o, 1);
        chk("reset stall_o", stall_o, 0);
        chk("reset result_o", result_o, 0);
        @(posedge clk); #1;
        rst_ni = 1;

        chk("model MUL", ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
        chk("model MULHU", ref_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
        chk("model MULHSU", ref_op(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
        chk("model DIV", ref_op(3'd4, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
        chk("model REM", ref_op(3'd6, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
        chk("model REM ovf", ref_op(3'd6, 32'h80000000, 32'hFFFFFFFF), 32'h0);

        dir("MUL 7*-3",       3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        dir("MULHU -1*-1",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        dir("MULH -1*-1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
        dir("MULHSU -1*2",    3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
        dir("DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        dir("REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        dir("DIVU 100/7",     3'd5, 32'd100,      32'd7,        32'd14,       34);
        dir("REMU 100/7",     3'd7, 32'd100,      32'd7,        32'd2,        34);
        dir("DIVU 100/0",     3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 2);
        dir("REMU 100/0",     3'd7, 32'd100,      32'd0,        32'd100,      2);
        dir("DIV ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        dir("REM ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        2);
        dir("MULH minmin",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34);

        // flush mid-CALC
        valid_i = 1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd7;
        @(posedge clk); #1;
        valid_i = 0;
        repeat (12) begin @(posedge clk); #1; end
        flush_i = 1;
        @(posedge clk); #1;
        flush_i = 0;
        chk("flush ready_o", ready_o, 1);
        chk("flush busy_o", busy_o, 0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen = 1; end
        chk("flush no valid_o", seen, 0);
        dir("DIVU 9/3 after flush", 3'd5, 32'd9, 32'd3, 32'd3, 34);
        dir("MUL back-to-back",     3'd0, 32'd5, 32'd6, 32'd30, 34);

        // flush and valid together in DONE: flush wins
        valid_i = 1; flush_i = 1; funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd3;
        @(posedge clk); #1;
        valid_i = 0; flush_i = 0;
        chk("flush+valid busy_o", busy_o, 0);
        chk("flush+valid result_o", result_o, 32'd30);

        // asynchronous reset mid-CALC
        valid_i = 1; funct3_i = 3'd3; op_a_i = 32'hFFFFFFFF; op_b_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        valid_i = 0;
        repeat (10) begin @(posedge clk); #1; end
        rst_ni = 0;
        #1;
        chk("async rst valid_o", valid_o, 0);
        chk("async rst busy_o", busy_o, 0);
        chk("async rst ready_o", ready_o, 1);
        chk("async rst stall_o", stall_o, 0);
        chk("async rst result_o", result_o, 0);
        @(posedge clk); #1;
        rst_ni = 1;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen = 1; end
        chk("rst no valid_o", seen, 0);

        // random ops, busy-time input noise, random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom);
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: begin ra = $urandom_range(0, 200); rb = $urandom_range(1, 20); end
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(rf, ra, rb, 1'($urandom_range(0, 1)), r, l);
            chk("random result", r, ref_op(rf, ra, rb));
            chk("random latency", l, spec_case(rf, ra, rb) ? 2 : 34);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
